// File: rtl/mp_pool_ctrl_pkg.sv
// Shared definitions for the 2x2 / stride-2 max-pool sequencer.
//   POOL_K, POOL_S : window size and stride (the datapath assumes 2/2)
//   PIX_MAX_W      : widest pixel smax() can compare; callers sign-extend into it
//   pool_state_e   : sequencer FSM encoding
package mp_pool_ctrl_pkg;

  localparam int POOL_K    = 2;
  localparam int POOL_S    = 2;
  localparam int PIX_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pool_state_e;

  // Signed maximum; equal operands return b, which is the same value.
  function automatic logic signed [PIX_MAX_W-1:0] smax(
    input logic signed [PIX_MAX_W-1:0] a,
    input logic signed [PIX_MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mp_bram.sv
// Single-port block RAM, read-first.
//   addra/dina/wea/ena : port A address, write data, write enable, enable
//   rsta/regcea        : output register reset/enable (HIGH_PERFORMANCE only)
//   douta              : read data, 1 cycle after ena (LOW_LATENCY)
//                        or 2 cycles (HIGH_PERFORMANCE)
// Read data only updates on enabled cycles, so it holds between reads.
module mp_bram #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) ram[addra] <= dina;
      ram_data <= ram[addra];
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_outreg
      logic unused_ok;
      assign unused_ok = rsta ^ regcea;
      assign douta = ram_data;
    end else begin : g_outreg
      logic [RAM_WIDTH-1:0] douta_reg;
      always_ff @(posedge clka) begin
        if (rsta)        douta_reg <= '0;
        else if (regcea) douta_reg <= ram_data;
      end
      assign douta = douta_reg;
    end
  endgenerate

endmodule

// File: rtl/mp_pool_ctrl.sv
// 2x2 stride-2 max-pool sequencer for a row-major single-channel plane.
//   clka, rsta           : clock, async active-high reset
//   start, cfg_width/height : begin a plane (sampled in IDLE only)
//   in_valid/in_ready/in_data    : pixel input stream
//   out_valid/out_ready/out_data : pooled pixel output stream
//   busy : RUN or FLUSH;  done : 1-cycle end-of-plane pulse
// Even rows park horizontal pair maxima in a half-width line buffer; odd rows
// read them back and combine with their own pair to form one output per window.
module mp_pool_ctrl
  import mp_pool_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 416,
  parameter int DIM_W  = 9
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH  = MAX_W / POOL_K;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EXT_W  = PIX_MAX_W - DATA_W;

  pool_state_e       state;
  logic [DIM_W-1:0]  w_reg, h_reg, col, row;
  logic [DATA_W-1:0] hold;

  logic              accept, col_last, row_last, col_disc, row_disc, plane_last;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_q, pair_max, quad_max;
  logic signed [PIX_MAX_W-1:0] hold_x, pix_x, q_x, hp_x;

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign col_last   = (col == w_reg - DIM_W'(1));
  assign row_last   = (row == h_reg - DIM_W'(1));
  // Odd width leaves a lone even last column; odd height a lone even last row.
  assign col_disc   = col_last && !col[0];
  assign row_disc   = row_last && !row[0];
  assign plane_last = col_last && row_last;

  assign bram_we   = accept && !row[0] && col[0] && !row_disc;
  assign bram_en   = bram_we || (accept && row[0] && !col[0] && !col_disc);
  assign bram_addr = ADDR_W'(col >> $clog2(POOL_S));

  assign hold_x   = {{EXT_W{hold[DATA_W-1]}}, hold};
  assign pix_x    = {{EXT_W{in_data[DATA_W-1]}}, in_data};
  assign q_x      = {{EXT_W{bram_q[DATA_W-1]}}, bram_q};
  assign hp_x     = smax(hold_x, pix_x);
  assign pair_max = DATA_W'(hp_x);
  assign quad_max = DATA_W'(smax(hp_x, q_x));

  // Read data is only refreshed on the odd-row even-column read, so it stays
  // valid across any stall before the matching odd column arrives.
  mp_bram #(
    .RAM_WIDTH       (DATA_W),
    .RAM_DEPTH       (DEPTH),
    .RAM_PERFORMANCE ("LOW_LATENCY")
  ) u_bram (
    .addra  (bram_addr),
    .dina   (pair_max),
    .clka   (clka),
    .wea    (bram_we),
    .ena    (bram_en),
    .rsta   (1'b1),
    .regcea (1'b1),
    .douta  (bram_q)
  );

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state     <= ST_IDLE;
      w_reg     <= '0;
      h_reg     <= '0;
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A result loaded below in the same cycle overrides this clear.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            w_reg <= cfg_width;
            h_reg <= cfg_height;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
            state <= (cfg_height < DIM_W'(2)) ? ST_FLUSH : ST_RUN;
          end
        end

        ST_RUN: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if (!col[0]) hold <= in_data;
            if (row[0] && col[0]) begin
              out_data  <= quad_max;
              out_valid <= 1'b1;
            end
            if (plane_last) state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (!out_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_pool_ctrl.sv
// Self-checking bench for mp_pool_ctrl: scenario tasks drive planes, outputs
// are collected into got_q and compared against expectations in exp_q.
module tb_mp_pool_ctrl;

  localparam int DATA_W = 16;
  localparam int MAX_W  = 416;
  localparam int DIM_W  = 9;

  typedef logic signed [DATA_W-1:0] pix_t;

  logic              clka = 1'b0;
  logic              rsta = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_width = '0;
  logic [DIM_W-1:0]  cfg_height = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  mp_pool_ctrl #(.DATA_W(DATA_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clka(clka), .rsta(rsta), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clka = ~clka;

  int   n_checks = 0;
  int   n_errors = 0;
  pix_t exp_q[$];
  pix_t got_q[$];

  // driver results
  int acc, bubbles, stall_viol, hold_bad, done_cnt;
  bit tmo, busy_at_done;

  // Reference pooling: max over each complete 2x2 window, row-major order.
  function automatic void ref_pool(input int w, input int h, input pix_t pix[$]);
    for (int r = 0; r + 1 < h; r += 2)
      for (int c = 0; c + 1 < w; c += 2) begin
        pix_t m;
        m = pix[r*w + c];
        if (pix[r*w + c + 1] > m)     m = pix[r*w + c + 1];
        if (pix[(r+1)*w + c] > m)     m = pix[(r+1)*w + c];
        if (pix[(r+1)*w + c + 1] > m) m = pix[(r+1)*w + c + 1];
        exp_q.push_back(m);
      end
  endfunction

  task automatic do_start(input int w, input int h);
    @(negedge clka);
    start = 1'b1; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    @(negedge clka);
    start = 1'b0; cfg_width = DIM_W'($urandom); cfg_height = DIM_W'($urandom);
  endtask

  // Inputs change at negedge; handshakes are judged #1 later for the next posedge.
  task automatic drive(input pix_t pix[$], input int stall_len, input int stop_after,
                       input int mid_start_at);
    int   idx = 0;
    int   stall_left = 0;
    bit   stalled = 0, mid_done = 0;
    pix_t held = '0;
    acc = 0; bubbles = 0; stall_viol = 0; hold_bad = 0; done_cnt = 0;
    tmo = 1; busy_at_done = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clka);
      start = 1'b0;
      if (stall_len > 0 && !stalled && out_valid) begin
        stalled = 1; stall_left = stall_len; held = out_data;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < pix.size()) && (stop_after < 0 || idx < stop_after);
      in_data   = in_valid ? pix[idx] : '0;
      if (mid_start_at >= 0 && !mid_done && idx == mid_start_at) begin
        mid_done = 1; start = 1'b1; cfg_width = DIM_W'(2); cfg_height = DIM_W'(8);
      end
      #1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (stall_left > 0) begin
        if (in_ready) stall_viol++;
        if (!out_valid || out_data !== held) hold_bad++;
        stall_left--;
      end
      if (in_valid && in_ready) begin idx++; acc++; end
      else if (in_valid && out_ready) bubbles++;
      if (done) begin done_cnt++; if (busy) busy_at_done = 1; end
      if (stop_after >= 0 && acc == stop_after) begin tmo = 0; break; end
      if (done_cnt > 0) begin tmo = 0; break; end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clka);
    n_checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_state got rdy=%b ov=%b busy=%b done=%b od=%0d want all 0",
               in_ready, out_valid, busy, done, out_data);
    end
    @(negedge clka);
    rsta = 1'b0;
    @(negedge clka);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    pix_t p[$];
    int   t[8] = '{1, 5, -3, 2, 4, 0, -7, -1};
    int   extra_done = 0;
    foreach (t[i]) p.push_back(pix_t'(t[i]));
    exp_q.push_back(16'sd5); exp_q.push_back(16'sd2);
    do_start(4, 2);
    drive(p, 0, -1, -1);
    n_checks++;
    if (tmo) begin n_errors++; $display("FAIL basic_timeout got no done want done"); end
    n_checks++;
    if (busy_at_done) begin n_errors++; $display("FAIL basic_busy_at_done got 1 want 0"); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clka);
      if (done || busy) extra_done++;
    end
    n_checks++;
    if (extra_done != 0 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL basic_done_once got done_cnt=%0d extra=%0d want 1 0", done_cnt, extra_done);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      pix_t g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL basic_data got %0d want %0d", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_square(input int mid_start);
    pix_t p[$];
    for (int i = 0; i < 16; i++) p.push_back(pix_t'(i));
    exp_q.push_back(16'sd5);  exp_q.push_back(16'sd7);
    exp_q.push_back(16'sd13); exp_q.push_back(16'sd15);
    do_start(4, 4);
    drive(p, 0, -1, mid_start);
    n_checks++;
    if (tmo || acc != 16) begin
      n_errors++; $display("FAIL square_accepts got %0d tmo=%0b want 16", acc, tmo);
    end
    n_checks++;
    if (bubbles != 0) begin n_errors++; $display("FAIL square_bubbles got %0d want 0", bubbles); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL square_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      pix_t g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL square_data got %0d want %0d", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    pix_t p[$];
    int   t[8] = '{1, 5, -3, 2, 4, 0, -7, -1};
    foreach (t[i]) p.push_back(pix_t'(t[i]));
    exp_q.push_back(16'sd5); exp_q.push_back(16'sd2);
    do_start(4, 2);
    drive(p, 5, -1, -1);
    n_checks++;
    if (tmo || acc != 8) begin n_errors++; $display("FAIL bp_accepts got %0d want 8", acc); end
    n_checks++;
    if (stall_viol != 0) begin n_errors++; $display("FAIL bp_in_ready got %0d want 0", stall_viol); end
    n_checks++;
    if (hold_bad != 0) begin n_errors++; $display("FAIL bp_hold got %0d want 0", hold_bad); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      pix_t g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL bp_data got %0d want %0d", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_odd_dims();
    pix_t p[$];
    for (int i = 0; i < 15; i++) p.push_back(16'sd3);
    p[9]  = 16'sd100;   // row 1, last column
    p[12] = 16'sd100;   // row 2, middle
    exp_q.push_back(16'sd3); exp_q.push_back(16'sd3);
    do_start(5, 3);
    drive(p, 0, -1, -1);
    n_checks++;
    if (tmo || acc != 15) begin n_errors++; $display("FAIL odd_accepts got %0d want 15", acc); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL odd_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      pix_t g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL odd_data got %0d want %0d", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    pix_t p[$];
    for (int i = 0; i < 16; i++) p.push_back(pix_t'(i));
    do_start(4, 4);
    drive(p, 0, 6, -1);
    n_checks++;
    if (tmo) begin n_errors++; $display("FAIL midrst_partial got tmo want 6 accepts"); end
    @(negedge clka);
    rsta = 1'b1;
    #1;
    n_checks++;
    if ({busy, out_valid, in_ready, done} !== 4'b0000 || out_data !== '0) begin
      n_errors++;
      $display("FAIL midrst_state got busy=%b ov=%b rdy=%b done=%b od=%0d want all 0",
               busy, out_valid, in_ready, done, out_data);
    end
    @(negedge clka);
    rsta = 1'b0;
    got_q.delete(); exp_q.delete();
    test_basic();
  endtask

  task automatic test_short_plane();
    do_start(4, 1);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_errors++; $display("FAIL short_c1 got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clka);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL short_c2 got done=%b busy=%b ov=%b want 1 0 0", done, busy, out_valid);
    end
    @(negedge clka);
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL short_c3 got done=%b want 0", done); end
  endtask

  task automatic test_random();
    int dims[3][2] = '{'{6, 5}, '{2, 2}, '{7, 4}};
    for (int k = 0; k < 3; k++) begin
      pix_t p[$];
      int   w, h;
      w = dims[k][0]; h = dims[k][1];
      for (int i = 0; i < w*h; i++) p.push_back(pix_t'($urandom_range(0, 65535)));
      ref_pool(w, h, p);
      do_start(w, h);
      drive(p, 0, -1, -1);
      n_checks++;
      if (tmo || acc != w*h) begin
        n_errors++; $display("FAIL rand_accepts got %0d want %0d", acc, w*h);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        pix_t g, e;
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL rand_data got %0d want %0d", g, e); end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_square(-1);
    test_backpressure();
    test_odd_dims();
    test_mid_reset();
    test_square(3);
    test_short_plane();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mp_pool_ctrl.md
Name: mp_pool_ctrl

Overview:
- Sequencer for a 2x2, stride-2 max-pool layer on a single-channel feature-map plane streamed in row-major order, one pixel per cycle.
- Owns one mp_bram instance (LOW_LATENCY, 1-cycle read) used as a half-width line buffer.
- Even rows: stores horizontal pair maxima in the buffer. Odd rows: reads them back and emits one pooled pixel per 2x2 window.
- Sits between the conv output stream and the next layer's input stream.

Parameters:
DATA_W, 16, signed fixed-point pixel width
MAX_W, 416, maximum plane width in pixels (even)
DIM_W, 9, width of cfg_width/cfg_height fields

Ports:
clka  in  1  clock
rsta  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_* and begins a plane (ignored unless IDLE)
cfg_width  in  DIM_W  plane width, valid range 2..MAX_W
cfg_height  in  DIM_W  plane height, valid range 0..2^DIM_W-1
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_data  in  DATA_W  input pixel, signed
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  pooled pixel, signed
busy  out  1  high in RUN or FLUSH
done  out  1  one-cycle pulse at end of plane

Behaviour:
- Reset (async, rsta=1): state=IDLE; col=0, row=0; hold=0; out_valid=0, out_data=0, in_ready=0, busy=0, done=0. BRAM contents are not cleared; stale data is harmless because every even row rewrites before any read.
- IDLE: on start, latch W=cfg_width, H=cfg_height.
  - If H<2: go to FLUSH directly.
  - Otherwise go to RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; does not depend on in_valid.
- Accept = in_valid&&in_ready. Counters advance only on accept: col wraps at W-1 to 0 and increments row.
- Even row (row[0]=0):
  - Even col: hold<=in_data.
  - Odd col: BRAM write, addr=col>>1, data=signed max(hold,in_data).
- Odd row:
  - Even col: hold<=in_data; issue BRAM read at col>>1 (ena=1, wea=0). Read data is valid from the next cycle and stays stable until the next read.
  - Odd col: out_data<=signed max(hold, in_data, bram_q); out_valid<=1.
- BRAM ena is asserted only on these write/read cycles; otherwise 0. regcea=1; the mp_bram rsta pin is tied 1 (unused in LOW_LATENCY).
- out_valid clears on out_ready when no new result is loaded in the same cycle. Simultaneous handshake-out and new result: register reloads, out_valid stays 1.
- Odd W: the last column of each row is accepted and discarded (no write/read). Output width = floor(W/2).
- Odd H: the last row is accepted and discarded. Output height = floor(H/2).
- The last pixel (row=H-1, col=W-1) accepted moves the FSM to FLUSH.
- FLUSH: wait until out_valid==0, then assert done for 1 cycle and return to IDLE.
- start in RUN/FLUSH: ignored. cfg_* changes after start: no effect.
- Throughput: 1 pixel/cycle with out_ready held high. No bubbles at row or plane boundaries except the FLUSH exit.
- Compare rule: signed two's-complement. On ties, any operand is acceptable because the values are equal.

Decomposition:
- Shared package: POOL_K=2 and POOL_S=2 constants; FSM state encoding (IDLE, RUN, FLUSH); a signed max function of DATA_W.
- Sub-module: the existing mp_bram, instantiated with RAM_WIDTH=DATA_W and RAM_DEPTH=MAX_W/2. No new sub-module.

Test Plan:
1. W=4,H=2, row0 = 1,5,-3,2 and row1 = 4,0,-7,-1, out_ready=1 -> outputs 5 then 2; done pulses once; busy falls with done.
2. W=4,H=4, pixels 0..15 row-major -> outputs 5,7,13,15 in order; no in_ready bubbles.
3. Test 1 with out_ready held 0 for 5 cycles after the first output -> in_ready stays 0 while out_valid=1; out_data holds 5 stable; no pixel lost; final outputs 5,2.
4. W=5,H=3, all pixels = 3 except a 100 at the last column of row 1 and a 100 in row 2 -> outputs 3,3 only; discarded column/row never appear; done after 15 accepts.
5. Assert rsta mid-plane (after 6 accepts of a W=4,H=4 plane), then restart W=4,H=2 with test 1 data -> outputs 5,2; no stale rows leak through.
6. Pulse start during RUN with different cfg values -> ignored; plane completes with the original W/H. Also start with H=1 -> no outputs, done 2 cycles after start.
